// File: rtl/fir_filter_param.sv
// Parametrised direct-form FIR filter with valid/ready streaming on both sides
// and run-time coefficient reload. One output per accepted sample, fixed
// two-edge latency, results rounded, shifted and saturated to DATA_W bits.
module fir_filter_param #(
   parameter int                     DATA_W    = 8,
   parameter int                     COEF_W    = 8,
   parameter int                     TAPS      = 4,
   parameter int                     OUT_SHIFT = 8,
   parameter int                     SIGNED    = 0,
   parameter logic [TAPS*COEF_W-1:0] COEF_INIT = {8'h33, 8'h66, 8'h33, 8'h19}
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic                    in_valid,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    in_ready,
   output logic                    out_valid,
   output logic [DATA_W-1:0]       out_data,
   input  logic                    out_ready,
   input  logic                    coef_we,
   input  logic [$clog2(TAPS)-1:0] coef_addr,
   input  logic [COEF_W-1:0]       coef_wdata
);

   // Product width: one extra bit per operand so unsigned values stay positive
   // when handled as signed numbers.
   localparam int PW = DATA_W + COEF_W + 2;
   // Accumulator: room for the sum of all taps plus the rounding carry.
   localparam int AW = PW + $clog2(TAPS) + 1;

   localparam longint MAX_I = (SIGNED != 0) ? ((longint'(1) <<< (DATA_W - 1)) - 1)
                                            : ((longint'(1) <<< DATA_W) - 1);
   localparam longint MIN_I = (SIGNED != 0) ? -(longint'(1) <<< (DATA_W - 1)) : 0;
   localparam logic signed [AW-1:0] MAXV = AW'(MAX_I);
   localparam logic signed [AW-1:0] MINV = AW'(MIN_I);
   localparam logic signed [AW-1:0] RND  =
      (OUT_SHIFT > 0) ? AW'(longint'(1) <<< ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;

   logic [DATA_W-1:0]    x_q [TAPS];
   logic                 x_valid;
   logic [COEF_W-1:0]    h_q [TAPS];
   logic signed [PW-1:0] p_d [TAPS];
   logic signed [PW-1:0] p_q [TAPS];
   logic                 p_valid;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] rnd_sum;
   logic signed [AW-1:0] shifted;
   logic [DATA_W-1:0]    sat;
   logic                 en;

   // The whole pipeline moves only when the output register is free or being drained.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // Coefficient bank: reset image, writes at any time, out-of-range indices ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < TAPS; k++) h_q[k] <= COEF_INIT[k*COEF_W +: COEF_W];
      end else if (coef_we && (32'(coef_addr) < 32'(TAPS))) begin
         h_q[coef_addr] <= coef_wdata;
      end
   end

   // Delay line: shifts only on an accepted sample; clear wins over accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
         x_valid <= 1'b0;
      end else if (clear) begin
         for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
         x_valid <= 1'b0;
      end else if (en) begin
         x_valid <= in_valid;
         if (in_valid) begin
            x_q[0] <= in_data;
            for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
         end
      end
   end

   // Per-tap multipliers, operands sign- or zero-extended by the SIGNED mode.
   for (genvar k = 0; k < TAPS; k++) begin : g_tap
      logic                   x_sign;
      logic                   h_sign;
      logic signed [DATA_W:0] x_ext;
      logic signed [COEF_W:0] h_ext;
      assign x_sign = (SIGNED != 0) && x_q[k][DATA_W-1];
      assign h_sign = (SIGNED != 0) && h_q[k][COEF_W-1];
      assign x_ext  = {x_sign, x_q[k]};
      assign h_ext  = {h_sign, h_q[k]};
      assign p_d[k] = PW'(x_ext) * PW'(h_ext);
   end

   // Product register stage with its own valid bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < TAPS; k++) p_q[k] <= '0;
         p_valid <= 1'b0;
      end else if (clear) begin
         for (int k = 0; k < TAPS; k++) p_q[k] <= '0;
         p_valid <= 1'b0;
      end else if (en) begin
         for (int k = 0; k < TAPS; k++) p_q[k] <= p_d[k];
         p_valid <= x_valid;
      end
   end

   // Sum the registered products, then round half-up and shift arithmetically.
   always_comb begin
      acc = '0;
      for (int k = 0; k < TAPS; k++) acc = acc + AW'(p_q[k]);
      rnd_sum = acc + RND;
      shifted = rnd_sum >>> OUT_SHIFT;
   end

   // Clamp the shifted sum into the output range of the selected number format.
   always_comb begin
      if (shifted > MAXV)      sat = MAXV[DATA_W-1:0];
      else if (shifted < MINV) sat = MINV[DATA_W-1:0];
      else                     sat = shifted[DATA_W-1:0];
   end

   // Output register: holds data while stalled, valid follows the product stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (clear) begin
         out_valid <= 1'b0;
      end else if (en) begin
         out_valid <= p_valid;
         if (p_valid) out_data <= sat;
      end
   end

endmodule

// File: tb/tb_fir_filter_param.sv
// Bench for fir_filter_param: one default unsigned 4-tap instance (a_*) and
// one signed 5-tap instance (b_*). Expected outputs are hand-computed and
// queued at acceptance; a monitor pops and compares on each output transfer.
module tb_fir_filter_param;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_coef_we;
   logic [7:0] a_in_data, a_out_data, a_coef_wdata;
   logic [1:0] a_coef_addr;

   logic       b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_coef_we;
   logic [7:0] b_in_data, b_out_data, b_coef_wdata;
   logic [2:0] b_coef_addr;

   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   int vectors = 0;
   int miscompares = 0;

   fir_filter_param dut_a (
      .clk(clk), .rst_n(rst_n), .clear(a_clear),
      .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
      .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
      .coef_we(a_coef_we), .coef_addr(a_coef_addr), .coef_wdata(a_coef_wdata)
   );

   fir_filter_param #(
      .DATA_W(8), .COEF_W(8), .TAPS(5), .OUT_SHIFT(8), .SIGNED(1),
      .COEF_INIT(40'h07_33_66_33_19)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(b_clear),
      .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
      .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
      .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_wdata(b_coef_wdata)
   );

   function automatic void check(input string name, input logic [7:0] act, input logic [7:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, want, $time);
      end
   endfunction

   // Monitor: pops one expectation per transfer; while stalled, in_ready must be
   // low and out_data must already show the next expected value.
   always @(negedge clk) begin
      if (rst_n) begin
         if (a_out_valid && a_out_ready) begin
            if (exp_a.size() == 0) check("a_unexpected_output", a_out_data, 8'hxx);
            else check("a_out_data", a_out_data, exp_a.pop_front());
         end else if (a_out_valid) begin
            check("a_stall_in_ready", 8'(a_in_ready), 8'h00);
            if (exp_a.size() != 0) check("a_stall_hold", a_out_data, exp_a[0]);
         end
         if (b_out_valid && b_out_ready) begin
            if (exp_b.size() == 0) check("b_unexpected_output", b_out_data, 8'hxx);
            else check("b_out_data", b_out_data, exp_b.pop_front());
         end
      end
   end

   task automatic applyStimulus(input bit sel, input logic [7:0] d, input logic [7:0] want);
      bit ok = 1'b0;
      int n = 0;
      if (sel) begin b_in_valid = 1'b1; b_in_data = d; end
      else     begin a_in_valid = 1'b1; a_in_data = d; end
      while (!ok && n < 100) begin
         @(negedge clk);
         ok = sel ? b_in_ready : a_in_ready;
         @(posedge clk);
         if (ok) begin
            if (sel) exp_b.push_back(want);
            else     exp_a.push_back(want);
         end
         #1;
         n++;
      end
      if (sel) b_in_valid = 1'b0;
      else     a_in_valid = 1'b0;
      if (!ok) check("accept_timeout", 8'h00, 8'h01);
   endtask

   task automatic writeCoef(input bit sel, input int addr, input logic [7:0] val);
      if (sel) begin b_coef_we = 1'b1; b_coef_addr = 3'(addr); b_coef_wdata = val; end
      else     begin a_coef_we = 1'b1; a_coef_addr = 2'(addr); a_coef_wdata = val; end
      @(posedge clk); #1;
      a_coef_we = 1'b0;
      b_coef_we = 1'b0;
   endtask

   task automatic pulseClear();
      a_clear = 1'b1;
      @(posedge clk); #1;
      a_clear = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (n >= 200) begin
         check("drain_timeout", 8'(exp_a.size() + exp_b.size()), 8'h00);
         exp_a.delete();
         exp_b.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      a_clear = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 1;
      a_coef_we = 0; a_coef_addr = 0; a_coef_wdata = 0;
      b_clear = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 1;
      b_coef_we = 0; b_coef_addr = 0; b_coef_wdata = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_a_out_valid", 8'(a_out_valid), 8'h00);
      check("rst_a_out_data", a_out_data, 8'h00);
      check("rst_a_in_ready", 8'(a_in_ready), 8'h01);
      check("rst_b_out_valid", 8'(b_out_valid), 8'h00);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Impulse, with first output two edges after acceptance
      applyStimulus(0, 8'hFF, 8'h19);
      check("lat_edge1_valid", 8'(a_out_valid), 8'h00);
      applyStimulus(0, 8'h00, 8'h33);
      check("lat_edge2_valid", 8'(a_out_valid), 8'h00);
      applyStimulus(0, 8'h00, 8'h66);
      check("lat_edge3_valid", 8'(a_out_valid), 8'h01);
      check("lat_edge3_data", a_out_data, 8'h19);
      applyStimulus(0, 8'h00, 8'h33);
      applyStimulus(0, 8'h00, 8'h00);
      drain();

      // Step: partial sums 25,76,178,229 times 255, rounded >>8 -> 19,4C,B1,E4
      applyStimulus(0, 8'hFF, 8'h19);
      applyStimulus(0, 8'hFF, 8'h4C);
      applyStimulus(0, 8'hFF, 8'hB1);
      for (int i = 0; i < 5; i++) applyStimulus(0, 8'hFF, 8'hE4);
      drain();
      pulseClear();

      // Same step with five cycles of downstream backpressure mid-stream
      fork
         begin
            applyStimulus(0, 8'hFF, 8'h19);
            applyStimulus(0, 8'hFF, 8'h4C);
            applyStimulus(0, 8'hFF, 8'hB1);
            for (int i = 0; i < 5; i++) applyStimulus(0, 8'hFF, 8'hE4);
         end
         begin
            repeat (4) @(posedge clk);
            #1 a_out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 a_out_ready = 1'b1;
         end
      join
      drain();
      pulseClear();

      // Coefficient reload to all 0xFF: 65025 -> FE, then saturation at FF
      for (int k = 0; k < 4; k++) writeCoef(0, k, 8'hFF);
      applyStimulus(0, 8'hFF, 8'hFE);
      for (int i = 0; i < 5; i++) applyStimulus(0, 8'hFF, 8'hFF);
      drain();

      // Mid-stream reset discards in-flight results and restores COEF_INIT
      for (int i = 0; i < 3; i++) applyStimulus(0, 8'hFF, 8'hFF);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 8'(a_out_valid), 8'h00);
      check("midrst_out_data", a_out_data, 8'h00);
      exp_a.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus(0, 8'hFF, 8'h19);
      applyStimulus(0, 8'h00, 8'h33);
      applyStimulus(0, 8'h00, 8'h66);
      applyStimulus(0, 8'h00, 8'h33);
      applyStimulus(0, 8'h00, 8'h00);
      drain();

      // Clear together with a valid sample after three samples (10,20,30)
      applyStimulus(0, 8'h10, 8'h02);
      applyStimulus(0, 8'h20, 8'h06);
      applyStimulus(0, 8'h30, 8'h11);
      a_in_valid = 1'b1; a_in_data = 8'h40; a_clear = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0; a_clear = 1'b0;
      check("clear_out_valid", 8'(a_out_valid), 8'h00);
      exp_a.delete();
      applyStimulus(0, 8'hFF, 8'h19);
      applyStimulus(0, 8'h00, 8'h33);
      applyStimulus(0, 8'h00, 8'h66);
      applyStimulus(0, 8'h00, 8'h33);
      applyStimulus(0, 8'h00, 8'h00);
      drain();

      // Writes to tap indices 5..7 on the 5-tap instance must change nothing
      for (int k = 5; k < 8; k++) writeCoef(1, k, 8'h80);
      applyStimulus(1, 8'h40, 8'h06);
      applyStimulus(1, 8'h00, 8'h0D);
      applyStimulus(1, 8'h00, 8'h1A);
      applyStimulus(1, 8'h00, 8'h0D);
      applyStimulus(1, 8'h00, 8'h02);
      applyStimulus(1, 8'h00, 8'h00);
      drain();

      // Signed: h[0]=-128, x=-128 -> +64; later taps give negative, floor-rounded values
      writeCoef(1, 0, 8'h80);
      applyStimulus(1, 8'h80, 8'h40);
      applyStimulus(1, 8'h00, 8'hE7);
      applyStimulus(1, 8'h00, 8'hCD);
      applyStimulus(1, 8'h00, 8'hE7);
      applyStimulus(1, 8'h00, 8'hFD);
      applyStimulus(1, 8'h00, 8'h00);
      drain();

      // Signed positive clamp: 2*(-128*-128)=32768 -> 128 -> 7F
      writeCoef(1, 1, 8'h80);
      applyStimulus(1, 8'h80, 8'h40);
      applyStimulus(1, 8'h80, 8'h7F);
      applyStimulus(1, 8'h00, 8'h0D);
      applyStimulus(1, 8'h00, 8'hB4);
      applyStimulus(1, 8'h00, 8'hE3);
      applyStimulus(1, 8'h00, 8'hFD);
      applyStimulus(1, 8'h00, 8'h00);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
